mips_divider: RTL and testbench

- Multicycle signed 32-bit divider for MIPS `div`. Sits beside the multiplier in the datapath.
- Consumes the register-bank read outputs (rs, rt) and produces HI (remainder) and LO (quotient) for the write-back mux.
- Handshakes with the control unit through start/state outputs. Raises a flag on divide-by-zero so the control unit can take the exception path.

---
 rtl/mips_div_pkg.sv | 6 +
 rtl/div_step.sv | 19 +
 rtl/mips_divider.sv | 73 +++++++
 tb/tb_mips_divider.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// mips_div_pkg: shared state encoding and sizing for the MIPS divider
package mips_div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ERR = 2'd3} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on magnitudes
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH:0]   trial;
    always_comb begin
        rem_sh   = {rem[WIDTH-2:0], quo[WIDTH-1]};
        trial    = {1'b0, rem_sh} - {1'b0, divisor};
        rem_next = trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/mips_divider.sv
// mips_divider: multicycle signed divider producing HI (remainder) and LO (quotient)
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int STEPS = DIV_STEPS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [1:0]       stateOut
);
    localparam int CW = $clog2(STEPS);
    div_state_t state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
    logic             sign_q, sign_r, start;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem),
        .quo(quo),
        .divisor(dvs),
        .rem_next(rem_n),
        .quo_next(quo_n)
    );
    always_comb begin
        start    = state == IDLE && enable && B != '0;
        state_n  = state == IDLE ? (enable ? (B == '0 ? ERR : RUN) : IDLE)
                 : state == RUN  ? (cnt == '0 ? DONE : RUN)
                 : IDLE;
        busy     = state == RUN;
        done     = state == DONE;
        div_zero = state == ERR;
        stateOut = state;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            state <= state_n;
            if (start) begin
                dvs    <= B[WIDTH-1] ? -B : B;
                quo    <= A[WIDTH-1] ? -A : A;
                rem    <= '0;
                cnt    <= CW'(STEPS - 1);
                sign_q <= A[WIDTH-1] ^ B[WIDTH-1];
                sign_r <= A[WIDTH-1];
            end else if (state == RUN) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt == '0 ? cnt : cnt - CW'(1);
                if (cnt == '0) begin
                    LO <= sign_q ? -quo_n : quo_n;
                    HI <= sign_r ? -rem_n : rem_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider: directed table, corner sequences and random model check for mips_divider
module tb_mips_divider;
    logic        clock = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [31:0] A = '0, B = '0, HI, LO;
    logic        busy, done, div_zero;
    logic [1:0]  stateOut;
    int          tests = 0, fails = 0;

    mips_divider dut (
        .clock(clock), .reset(reset), .enable(enable), .A(A), .B(B),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero), .stateOut(stateOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a, b, lo, hi;
        logic        zero;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse enable for one edge, then follow the op until done/div_zero or a cycle budget runs out.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output bit got_done, output bit got_zero);
        @(negedge clock);
        A = a; B = b; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0;
        nbusy = 0; got_done = 0; got_zero = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) nbusy++;
            if (done) begin got_done = 1; break; end
            if (div_zero) begin got_zero = 1; break; end
            @(negedge clock);
        end
    endtask

    vec_t vecs[12];
    int   nb;
    bit   gd, gz;

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0};
        vecs[3]  = '{32'd5,         32'd0,         32'hFFFFFFF2,  32'd2,         1'b1};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
        vecs[5]  = '{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0};
        vecs[6]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0};
        vecs[7]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0};
        vecs[8]  = '{32'd1,         32'h7FFFFFFF,  32'd0,         32'd1,         1'b0};
        vecs[9]  = '{32'h7FFFFFFF,  32'd2,         32'h3FFFFFFF,  32'd1,         1'b0};
        vecs[10] = '{32'hFFFFFFFF,  32'h80000000,  32'd0,         32'hFFFFFFFF,  1'b0};
        vecs[11] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0};

        repeat (3) @(negedge clock);
        chk("reset_state", {30'd0, stateOut}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_flags", {29'd0, busy, done, div_zero}, 32'd0);
        reset = 1'b0;

        // Latency and stateOut sequence for the first request
        @(negedge clock);
        A = 32'd100; B = 32'd7; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("seq_run_state", {30'd0, stateOut}, 32'd1);
            chk("seq_run_busy", {31'd0, busy}, 32'd1);
            @(negedge clock);
        end
        chk("seq_done_state", {30'd0, stateOut}, 32'd2);
        chk("seq_done_pulse", {30'd0, done, busy}, 32'd2);
        chk("seq_lo", LO, 32'd14);
        chk("seq_hi", HI, 32'd2);
        @(negedge clock);
        chk("seq_idle_state", {30'd0, stateOut}, 32'd0);
        chk("seq_done_clear", {31'd0, done}, 32'd0);

        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, nb, gd, gz);
            if (vecs[k].zero) begin
                chk("tbl_zero_flag", {31'd0, gz}, 32'd1);
                chk("tbl_zero_state", {30'd0, stateOut}, 32'd3);
                chk("tbl_zero_busy", nb, 32'd0);
            end else begin
                chk("tbl_done", {31'd0, gd}, 32'd1);
                chk("tbl_busy_cycles", nb, 32'd32);
            end
            chk("tbl_lo", LO, vecs[k].lo);
            chk("tbl_hi", HI, vecs[k].hi);
            @(negedge clock);
            chk("tbl_back_idle", {29'd0, stateOut, done | div_zero}, 32'd0);
        end

        // Divide by zero: no done afterwards either, results untouched
        gd = 0;
        run_op(32'd5, 32'd0, nb, gd, gz);
        for (int i = 0; i < 36; i++) begin
            @(negedge clock);
            if (done) gd = 1;
        end
        chk("zero_no_done", {31'd0, gd}, 32'd0);
        chk("zero_lo_kept", LO, 32'd1);
        chk("zero_hi_kept", HI, 32'd0);

        // Second enable during RUN ignored, then reset aborts the division
        @(negedge clock);
        A = 32'd1000; B = 32'd3; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        repeat (9) @(negedge clock);
        A = 32'd9; B = 32'd9; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        chk("abort_still_run", {30'd0, stateOut}, 32'd1);
        repeat (9) @(negedge clock);
        chk("abort_pre_reset", {30'd0, stateOut}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_state", {30'd0, stateOut}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        gd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) gd = 1;
        end
        chk("abort_no_done", {31'd0, gd}, 32'd0);

        // Random signed pairs against a truncating-division model
        for (int n = 0; n < 500; n++) begin
            logic signed [31:0] ra, rb, elo, ehi;
            ra = $signed($urandom);
            rb = (n % 2) ? $signed($urandom) : $signed(32'($urandom_range(0, 200)) - 32'd100);
            if (rb == 0) rb = 1;
            if (ra == 32'sh80000000 && rb == -1) rb = 3;
            elo = ra / rb;
            ehi = ra - elo * rb;
            run_op(ra, rb, nb, gd, gz);
            chk("rnd_done", {31'd0, gd}, 32'd1);
            chk("rnd_lo", LO, elo);
            chk("rnd_hi", HI, ehi);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
